// File: rtl/rca_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rca_pipe                                                   |
// | Description : Parametrised pipelined ripple-carry adder/subtractor.      |
// |               N-bit operands are resolved W bits per stage; the slice    |
// |               carry is registered between stages, so latency is N/W.     |
// |               Valid/ready handshake on both sides, single global stall.  |
// | Option      : define RCA_PIPE_SAT_EN to clamp the sum on signed          |
// |               overflow (0111..1 / 1000..0) at the last stage register.   |
// | Ports       : clk, rst_n (sync, active-low)                              |
// |               in_valid/in_ready, a, b, cin, sub  - operand side          |
// |               out_valid/out_ready, sum, cout, ovf - result side          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rca_pipe #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int STAGES = N / W;

  // Per-stage state. r_a/r_b carry the effective operands (B already
  // inverted for subtraction) so later stages can consume their slice and
  // the last stage can form the signed-overflow flag from the MSBs.
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [N-1:0]      r_a [STAGES];
  logic [N-1:0]      r_b [STAGES];
  logic [N-1:0]      r_s [STAGES];
  logic              r_ovf;

  // Single global enable: the whole pipe moves unless the result is stuck.
  logic w_adv;
  assign w_adv = !r_vld[STAGES-1] | out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         w_v;
    logic         w_c;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_s;
    logic [W:0]   w_add;
    logic [N-1:0] w_nxt;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1; cin is ignored in that mode.
      assign w_v = in_valid;
      assign w_a = a;
      assign w_b = sub ? ~b : b;
      assign w_s = '0;
      assign w_c = sub ? 1'b1 : cin;
    end else begin : g_next
      assign w_v = r_vld[k-1];
      assign w_a = r_a[k-1];
      assign w_b = r_b[k-1];
      assign w_s = r_s[k-1];
      assign w_c = r_c[k-1];
    end

    assign w_add = {1'b0, w_a[k*W +: W]} + {1'b0, w_b[k*W +: W]} + {{W{1'b0}}, w_c};

    // Lower slices pass through untouched; this stage fills in slice k.
    always_comb begin
      w_nxt              = w_s;
      w_nxt[k*W +: W]    = w_add[W-1:0];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end else if (w_adv) begin
        r_vld[k] <= w_v;
        if (w_v) begin
          r_c[k] <= w_add[W];
          r_a[k] <= w_a;
          r_b[k] <= w_b;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic         w_ovf;
      logic [N-1:0] w_res;

      assign w_ovf = (w_a[N-1] == w_b[N-1]) & (w_nxt[N-1] != w_a[N-1]);

`ifdef RCA_PIPE_SAT_EN
      // Both operands share a sign on overflow; that sign picks the rail.
      always_comb begin
        w_res = w_nxt;
        if (w_ovf) begin
          w_res = w_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
      end
`else
      assign w_res = w_nxt;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s[k] <= '0;
          r_ovf  <= 1'b0;
        end else if (w_adv && w_v) begin
          r_s[k] <= w_res;
          r_ovf  <= w_ovf;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s[k] <= '0;
        end else if (w_adv && w_v) begin
          r_s[k] <= w_nxt;
        end
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rca_pipe                                                |
// | Description : Scoreboard bench for rca_pipe (N=16, W=4). The driver      |
// |               pushes hand-computed results on accept; a negedge monitor  |
// |               pops and compares on every output transfer, and checks     |
// |               hold-stability and in_ready while stalled.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rca_pipe;

  localparam int N      = 16;
  localparam int W      = 4;
  localparam int STAGES = N / W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  rca_pipe #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    bit           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: all DUT outputs are sampled on the falling edge, where they are
  // stable; a handshake seen here completes at the following rising edge.
  bit           held = 0;
  logic [N-1:0] h_s;
  logic         h_c;
  logic         h_o;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 0;
    end else begin
      if (held) begin
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold_sum", {16'd0, sum}, {16'd0, h_s});
        chk("stall_hold_cout_ovf", {30'd0, cout, ovf}, {30'd0, h_c, h_o});
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        held = 1;
        h_s  = sum;
        h_c  = cout;
        h_o  = ovf;
      end else begin
        held = 0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_out: got sum 0x%0h with no expected entry", sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", {16'd0, sum}, {16'd0, e.s});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("ovf", {31'd0, ovf}, {31'd0, e.o});
          if (e.lat) chk("latency", cyc - e.acc, STAGES);
        end
      end
    end
  end

  // Entered at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                       input logic isb, input logic [N-1:0] es, input logic ec,
                       input logic eo, input bit lat);
    bit   done;
    exp_t e;
    done     = 0;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    cin      = ic;
    sub      = isb;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = es; e.c = ec; e.o = eo; e.lat = lat; e.acc = cyc;
        q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'h0000);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Isolated ops: latency checked against STAGES.
    issue(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1); wait_drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1); wait_drain();
`ifdef RCA_PIPE_SAT_EN
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1); wait_drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1); wait_drain();
`else
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1); wait_drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1); wait_drain();
`endif
    issue(16'h1357, 16'h0000, 1'b1, 1'b1, 16'h1357, 1'b1, 1'b0, 1); wait_drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1); wait_drain();

    // Six back-to-back ops with a 3-cycle consumer stall after the first result.
    fork
      begin
        issue(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 0);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        issue(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 0);
        issue(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0);
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
`ifdef RCA_PIPE_SAT_EN
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
`else
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
`endif
      end
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        chk("first_result_timeout", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three ops in flight: none of them may appear.
    issue(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 0);
    issue(16'h0011, 16'h0021, 1'b0, 1'b0, 16'h0032, 1'b0, 1'b0, 0);
    issue(16'h0012, 16'h0022, 1'b0, 1'b0, 16'h0034, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
